// File: rtl/adxl_pkg.sv
// Shared constants for the ADXL362-style SPI responder:
// command bytes, register addresses and FSM state encoding.
package adxl_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [7:0] REVID_VAL      = 8'h02;

    localparam logic [5:0] A_DEVID_AD   = 6'h00;
    localparam logic [5:0] A_DEVID_MST  = 6'h01;
    localparam logic [5:0] A_PARTID     = 6'h02;
    localparam logic [5:0] A_REVID      = 6'h03;
    localparam logic [5:0] A_XDATA      = 6'h08;
    localparam logic [5:0] A_YDATA      = 6'h09;
    localparam logic [5:0] A_ZDATA      = 6'h0A;
    localparam logic [5:0] A_XDATA_L    = 6'h0E;
    localparam logic [5:0] A_XDATA_H    = 6'h0F;
    localparam logic [5:0] A_YDATA_L    = 6'h10;
    localparam logic [5:0] A_YDATA_H    = 6'h11;
    localparam logic [5:0] A_ZDATA_L    = 6'h12;
    localparam logic [5:0] A_ZDATA_H    = 6'h13;
    localparam logic [5:0] A_SOFT_RESET = 6'h1F;
    localparam logic [5:0] A_RW_FIRST   = 6'h20;
    localparam logic [5:0] A_RW_LAST    = 6'h2E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WADDR,
        ST_RADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    // High data byte: sign extension in [7:4], sample bits 11:8 in [3:0].
    function automatic logic [7:0] hi_byte(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI input,
// with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// SPI mode-0 target emulating the ADXL362 register interface,
// serving synthetic X/Y/Z samples and a small R/W register bank.
module adxl_spi_responder
    import adxl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] accel_x,
    input  logic [11:0] accel_y,
    input  logic [11:0] accel_z,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        cmd_error,
    output logic        busy
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk_i(ClkPort), .rst_ni(Reset_n), .d_i(sclk),
        .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk_i(ClkPort), .rst_ni(Reset_n), .d_i(mosi),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    // Reset low so a select held low across reset is not seen as a new fall.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss (
        .clk_i(ClkPort), .rst_ni(Reset_n), .d_i(ss_n),
        .lvl_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall, ss_lvl};

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shin_q, shout_q;
    logic [5:0]  addr_q, wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        wr_strobe_q, cmd_error_q, load_q;
    logic [35:0] snap_q;
    logic [7:0]  regs_q [16];
    logic [7:0]  byte_val, rd_data;
    logic        byte_done, cmd_bad, soft_clear;

    assign byte_done = sclk_rise && bit_cnt_q == 3'd7 && state_q != ST_IDLE;
    assign byte_val  = {shin_q[6:0], mosi_lvl};
    assign cmd_bad   = byte_done && state_q == ST_CMD &&
                       byte_val != CMD_WRITE && byte_val != CMD_READ;
    assign soft_clear = wr_strobe_q && wr_addr_q == A_SOFT_RESET &&
                        wr_data_q == SOFT_RESET_KEY;

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else if (ss_fall) begin
            state_d = ST_CMD;
        end else if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    if (byte_val == CMD_WRITE)     state_d = ST_WADDR;
                    else if (byte_val == CMD_READ) state_d = ST_RADDR;
                    else                           state_d = ST_IGNORE;
                end
                ST_WADDR: state_d = ST_WDATA;
                ST_RADDR: state_d = ST_RDATA;
                default:  state_d = state_q;
            endcase
        end
    end

    // Byte completion is honoured even when ss_n rises in the same cycle.
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt_q   <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            cmd_error_q <= 1'b0;
            load_q      <= 1'b0;
            snap_q      <= '0;
        end else begin
            wr_strobe_q <= byte_done && state_q == ST_WDATA;
            cmd_error_q <= cmd_bad;
            if (state_q == ST_IDLE || ss_fall) bit_cnt_q <= '0;
            else if (sclk_rise)               bit_cnt_q <= bit_cnt_q + 3'd1;
            if (sclk_rise) shin_q <= byte_val;
            if (byte_done) begin
                case (state_q)
                    ST_WADDR, ST_RADDR: addr_q <= byte_val[5:0];
                    ST_WDATA: begin
                        wr_addr_q <= addr_q;
                        wr_data_q <= byte_val;
                        addr_q    <= addr_q + 6'd1;
                    end
                    ST_RDATA: addr_q <= addr_q + 6'd1;
                    default: ;
                endcase
            end
            if (byte_done && state_q == ST_RADDR)
                snap_q <= {accel_z, accel_y, accel_x};
            if (state_q == ST_IDLE) begin
                load_q  <= 1'b0;
                shout_q <= '0;
            end else if (byte_done &&
                         (state_q == ST_RADDR || state_q == ST_RDATA)) begin
                load_q <= 1'b1;
            end else if (sclk_fall && state_q == ST_RDATA) begin
                load_q  <= 1'b0;
                shout_q <= load_q ? rd_data : {shout_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n || soft_clear) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (wr_strobe_q &&
                     wr_addr_q inside {[A_RW_FIRST:A_RW_LAST]}) begin
            regs_q[wr_addr_q[3:0]] <= wr_data_q;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_q) inside
            A_DEVID_AD:  rd_data = DEVID_AD;
            A_DEVID_MST: rd_data = DEVID_MST;
            A_PARTID:    rd_data = PARTID;
            A_REVID:     rd_data = REVID_VAL;
            A_XDATA:     rd_data = snap_q[11:4];
            A_YDATA:     rd_data = snap_q[23:16];
            A_ZDATA:     rd_data = snap_q[35:28];
            A_XDATA_L:   rd_data = snap_q[7:0];
            A_XDATA_H:   rd_data = hi_byte(snap_q[11:0]);
            A_YDATA_L:   rd_data = snap_q[19:12];
            A_YDATA_H:   rd_data = hi_byte(snap_q[23:12]);
            A_ZDATA_L:   rd_data = snap_q[31:24];
            A_ZDATA_H:   rd_data = hi_byte(snap_q[35:24]);
            [A_RW_FIRST:A_RW_LAST]: rd_data = regs_q[addr_q[3:0]];
            default:     rd_data = 8'h00;
        endcase
    end

    assign miso      = ~ss_n & (state_q == ST_RDATA) & shout_q[7];
    assign miso_oe   = state_q != ST_IDLE;
    assign busy      = state_q != ST_IDLE;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: SPI reads, writes,
// snapshot, soft reset, bad command, wrap and mid-transfer reset.
module tb_adxl_spi_responder;

    logic        ClkPort = 1'b0;
    logic        Reset_n = 1'b0;
    logic        sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic        miso, miso_oe, wr_strobe, cmd_error, busy;
    logic [11:0] accel_x = 12'h000, accel_y = 12'h000, accel_z = 12'h000;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    adxl_spi_responder dut (
        .ClkPort(ClkPort), .Reset_n(Reset_n),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_error(cmd_error), .busy(busy)
    );

    always #5 ClkPort = ~ClkPort;

    int checks = 0;
    int errors = 0;
    int hp = 500;
    logic [7:0] last_rx;
    logic [7:0] rxb [8];

    int         wcnt = 0, ecnt = 0;
    logic [5:0] wa [16];
    logic [7:0] wd [16];

    always @(posedge ClkPort) begin
        if (wr_strobe) begin
            if (wcnt < 16) begin
                wa[wcnt] = wr_addr;
                wd[wcnt] = wr_data;
            end
            wcnt++;
        end
        if (cmd_error) ecnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        last_rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #(hp / 2);
            last_rx[i] = miso;
            sclk = 1'b1;
            #(hp);
            sclk = 1'b0;
            #(hp / 2);
        end
    endtask

    task automatic xfer(input logic [7:0] tx);
        spi_bits(tx, 8);
    endtask

    task automatic cs_lo;
        ss_n = 1'b0;
        #500;
    endtask

    task automatic cs_hi;
        #250;
        ss_n = 1'b1;
        #750;
    endtask

    task automatic rd(input logic [7:0] addr, input int n);
        cs_lo();
        xfer(8'h0B);
        xfer(addr);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00);
            rxb[i] = last_rx;
        end
        cs_hi();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d0,
                      input logic [7:0] d1, input int n);
        cs_lo();
        xfer(8'h0A);
        xfer(addr);
        xfer(d0);
        if (n > 1) xfer(d1);
        cs_hi();
    endtask

    int w0, e0;

    initial begin
        // Reset state
        repeat (5) @(negedge ClkPort);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_cmd_error", cmd_error, 0);
        chk("rst_busy", busy, 0);
        Reset_n = 1'b1;
        repeat (10) @(negedge ClkPort);

        // ID registers at 1 MHz
        cs_lo();
        chk("id_busy_start", busy, 1);
        chk("id_miso_oe", miso_oe, 1);
        xfer(8'h0B);
        xfer(8'h00);
        xfer(8'h00); rxb[0] = last_rx;
        xfer(8'h00); rxb[1] = last_rx;
        xfer(8'h00); rxb[2] = last_rx;
        chk("id_busy_end", busy, 1);
        cs_hi();
        chk("id_ad", rxb[0], 8'hAD);
        chk("id_mst", rxb[1], 8'h1D);
        chk("id_part", rxb[2], 8'hF2);
        chk("id_busy_after", busy, 0);
        chk("id_miso_oe_after", miso_oe, 0);
        chk("id_miso_after", miso, 0);

        hp = 200;

        // Snapshot: sample changes during first data byte
        accel_x = 12'hF9C;
        accel_y = 12'hABC;
        accel_z = 12'h456;
        cs_lo();
        xfer(8'h0B);
        xfer(8'h0E);
        fork
            xfer(8'h00);
            begin #700; accel_x = 12'h123; end
        join
        rxb[0] = last_rx;
        xfer(8'h00);
        rxb[1] = last_rx;
        cs_hi();
        chk("snap_xl", rxb[0], 8'h9C);
        chk("snap_xh", rxb[1], 8'hFF);

        rd(8'h08, 3);
        chk("x_11_4", rxb[0], 8'h12);
        chk("y_11_4", rxb[1], 8'hAB);
        chk("z_11_4", rxb[2], 8'h45);
        rd(8'h10, 4);
        chk("y_lo", rxb[0], 8'hBC);
        chk("y_hi", rxb[1], 8'hFA);
        chk("z_lo", rxb[2], 8'h56);
        chk("z_hi", rxb[3], 8'h04);
        rd(8'h03, 1);
        chk("revid", rxb[0], 8'h02);

        // Burst write and readback
        w0 = wcnt;
        wr(8'h2D, 8'h02, 8'h11, 2);
        chk("wr_count", wcnt - w0, 2);
        chk("wr0_addr", wa[w0], 6'h2D);
        chk("wr0_data", wd[w0], 8'h02);
        chk("wr1_addr", wa[w0+1], 6'h2E);
        chk("wr1_data", wd[w0+1], 8'h11);
        rd(8'h2D, 2);
        chk("rb_2d", rxb[0], 8'h02);
        chk("rb_2e", rxb[1], 8'h11);

        // Soft reset key and non-key
        w0 = wcnt;
        wr(8'h1F, 8'h52, 8'h00, 1);
        chk("srst_strobe", wcnt - w0, 1);
        chk("srst_addr", wa[w0], 6'h1F);
        rd(8'h2D, 2);
        chk("srst_2d", rxb[0], 8'h00);
        chk("srst_2e", rxb[1], 8'h00);
        wr(8'h2D, 8'h55, 8'h00, 1);
        wr(8'h1F, 8'h00, 8'h00, 1);
        rd(8'h2D, 1);
        chk("nokey_2d", rxb[0], 8'h55);

        // Unsupported command
        w0 = wcnt;
        e0 = ecnt;
        cs_lo();
        xfer(8'h0D);
        xfer(8'hFF); rxb[0] = last_rx;
        chk("badcmd_miso_mid", miso, 0);
        xfer(8'hFF); rxb[1] = last_rx;
        cs_hi();
        chk("badcmd_err", ecnt - e0, 1);
        chk("badcmd_rx0", rxb[0], 8'h00);
        chk("badcmd_rx1", rxb[1], 8'h00);
        chk("badcmd_nowr", wcnt - w0, 0);

        // Wrap on write, partial third byte discarded
        w0 = wcnt;
        cs_lo();
        xfer(8'h0A);
        xfer(8'h3F);
        xfer(8'hA1);
        xfer(8'hB2);
        spi_bits(8'hC3, 5);
        cs_hi();
        chk("wrap_count", wcnt - w0, 2);
        chk("wrap0_addr", wa[w0], 6'h3F);
        chk("wrap0_data", wd[w0], 8'hA1);
        chk("wrap1_addr", wa[w0+1], 6'h00);
        chk("wrap1_data", wd[w0+1], 8'hB2);
        rd(8'h3F, 2);
        chk("rdwrap_3f", rxb[0], 8'h00);
        chk("rdwrap_00", rxb[1], 8'hAD);

        // Reset asserted mid-transaction
        w0 = wcnt;
        cs_lo();
        xfer(8'h0A);
        xfer(8'h20);
        spi_bits(8'h77, 4);
        Reset_n = 1'b0;
        #100;
        chk("midrst_busy", busy, 0);
        chk("midrst_oe", miso_oe, 0);
        Reset_n = 1'b1;
        #400;
        spi_bits(8'h77, 4);
        chk("midrst_idle", busy, 0);
        cs_hi();
        chk("midrst_nowr", wcnt - w0, 0);
        rd(8'h2D, 1);
        chk("midrst_2d", rxb[0], 8'h00);
        rd(8'h00, 1);
        chk("midrst_id", rxb[0], 8'hAD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
